// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button synchronizer, debouncer and press/hold event FSM.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat BTNOUT pulses while held).
module btn_conditioner #(
  parameter int DIV_W    = 17,
  parameter int STABLE_N = 8,
  parameter int LONG_N   = 1000,
  parameter int REPEAT_N = 200,
  parameter bit ACT_HIGH = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic BTNOUT,
  output logic BTNREL,
  output logic LONG,
  output logic BTNLVL
);

  localparam int SW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam int HN = (LONG_N > REPEAT_N) ? LONG_N : REPEAT_N;
  localparam int HW = (HN > 1) ? $clog2(HN) : 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_N - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_N - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST    = HW'(REPEAT_N - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic             raw;
  logic             s1;
  logic             s2;
  logic [DIV_W-1:0] presc;
  logic             tick;
  logic [SW-1:0]    stable;
  logic             diff;
  logic             settle;
  logic             rise;
  logic             fall;
  logic [HW-1:0]    hold;
  state_t           state;

  // Normalise polarity so that 1 always means pressed.
  assign raw = BTN ^ ~ACT_HIGH;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Free-running prescaler; one sample tick per wrap.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick   = &presc;
  assign diff   = s2 ^ BTNLVL;
  assign settle = tick & diff & (stable == STABLE_LAST);
  assign rise   = settle & ~BTNLVL;
  assign fall   = settle & BTNLVL;

  // Debouncer: level flips after STABLE_N consecutive differing ticks.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stable <= '0;
      BTNLVL <= 1'b0;
    end else if (tick) begin
      if (diff) begin
        if (stable == STABLE_LAST) begin
          BTNLVL <= ~BTNLVL;
          stable <= '0;
        end else begin
          stable <= stable + 1'b1;
        end
      end else begin
        stable <= '0;
      end
    end
  end

  // Press/hold FSM with registered single-cycle event pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      hold   <= '0;
      BTNOUT <= 1'b0;
      BTNREL <= 1'b0;
      LONG   <= 1'b0;
    end else begin
      BTNOUT <= 1'b0;
      BTNREL <= 1'b0;
      LONG   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state  <= PRESSED;
            BTNOUT <= 1'b1;
            hold   <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state  <= IDLE;
            BTNREL <= 1'b1;
          end else if (tick) begin
            if (hold == LONG_LAST) begin
              state <= HELD;
              LONG  <= 1'b1;
              hold  <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
        HELD: begin
          if (fall) begin
            state  <= IDLE;
            BTNREL <= 1'b1;
          end
`ifdef BTN_REPEAT_EN
          else if (tick) begin
            if (hold == REP_LAST) begin
              hold   <= '0;
              BTNOUT <= 1'b1;
            end else begin
              hold <= hold + 1'b1;
            end
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of btn_conditioner event timing.
// Two instances: active-high pin and active-low pin.
module tb_btn_conditioner;

  logic CLK = 1'b0;
  logic RST;
  logic BTN;
  logic btnout, btnrel, longp, btnlvl;
  logic rst_b;
  logic btn_b;
  logic btnout_b, btnrel_b, long_b, btnlvl_b;

  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;

  int q_out[$];
  int q_rel[$];
  int q_long[$];
  int q_out_b[$];
  int q_rel_b[$];
  int q_long_b[$];

  btn_conditioner #(
    .DIV_W(2), .STABLE_N(3), .LONG_N(5),
    .REPEAT_N(2), .ACT_HIGH(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .BTNOUT(btnout), .BTNREL(btnrel),
    .LONG(longp), .BTNLVL(btnlvl)
  );

  btn_conditioner #(
    .DIV_W(2), .STABLE_N(3), .LONG_N(5),
    .REPEAT_N(2), .ACT_HIGH(1'b0)
  ) dut_b (
    .CLK(CLK), .RST(rst_b), .BTN(btn_b),
    .BTNOUT(btnout_b), .BTNREL(btnrel_b),
    .LONG(long_b), .BTNLVL(btnlvl_b)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (btnout === 1'b1) q_out.push_back(cyc);
    if (btnrel === 1'b1) q_rel.push_back(cyc);
    if (longp === 1'b1) q_long.push_back(cyc);
    if (btnout_b === 1'b1) q_out_b.push_back(cyc);
    if (btnrel_b === 1'b1) q_rel_b.push_back(cyc);
    if (long_b === 1'b1) q_long_b.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  initial begin
    RST   = 1'b0;
    BTN   = 1'b1;
    rst_b = 1'b0;
    btn_b = 1'b1;

    // Reset held for edges 1..3 with the button pressed.
    wait_to(3);
    chk("rst_btnout", {31'd0, btnout}, 0);
    chk("rst_btnrel", {31'd0, btnrel}, 0);
    chk("rst_long", {31'd0, longp}, 0);
    chk("rst_btnlvl", {31'd0, btnlvl}, 0);
    RST = 1'b1;

    // Ticks land on edges 7, 11, 15, ...; press settles on edge 15.
    wait_to(14);
    chk("early_lvl", {31'd0, btnlvl}, 0);
    chk("early_out_cnt", q_out.size(), 0);
    wait_to(15);
    chk("press_lvl", {31'd0, btnlvl}, 1);
    chk("press_out_cnt", q_out.size(), 1);
    chk("press_out_cyc", qat(q_out, 0), 15);

    // Release before LONG: BTNREL on the third tick with s2 low.
    wait_to(20);
    BTN = 1'b0;
    wait_to(40);
    chk("rel_cyc", qat(q_rel, 0), 31);
    chk("rel_cnt", q_rel.size(), 1);
    chk("rel_no_long", q_long.size(), 0);
    chk("rel_lvl", {31'd0, btnlvl}, 0);
    chk("one_out", q_out.size(), 1);

    // Bounce: 5-CLK pulses never give three stable ticks.
    for (int i = 0; i < 6; i++) begin
      BTN = (i % 2 == 0);
      wait_to(40 + 5 * (i + 1));
    end
    BTN = 1'b0;
    wait_to(100);
    chk("bnc_out", q_out.size(), 1);
    chk("bnc_rel", q_rel.size(), 1);
    chk("bnc_lvl", {31'd0, btnlvl}, 0);

    // Long hold: press at 100, release at 160.
    BTN = 1'b1;
    wait_to(160);
    BTN = 1'b0;
    wait_to(180);
    chk("hold_out_cyc", qat(q_out, 1), 111);
    chk("long_cnt", q_long.size(), 1);
    chk("long_cyc", qat(q_long, 0), 131);
`ifdef BTN_REPEAT_EN
    chk("rep_cnt", q_out.size(), 6);
    chk("rep0", qat(q_out, 2), 139);
    chk("rep1", qat(q_out, 3), 147);
    chk("rep2", qat(q_out, 4), 155);
    chk("rep3", qat(q_out, 5), 163);
`else
    chk("norep_cnt", q_out.size(), 2);
`endif
    chk("rel2_cnt", q_rel.size(), 2);
    chk("rel2_cyc", qat(q_rel, 1), 171);
    chk("rel2_no_out", {31'd0, (q_out[q_out.size()-1] == 171)}, 0);
    chk("rel2_lvl", {31'd0, btnlvl}, 0);

    // Active-low instance: reset released at 180, ticks on 184, 188, ...
    rst_b = 1'b1;
    wait_to(190);
    btn_b = 1'b0;
    wait_to(203);
    chk("lo_early_lvl", {31'd0, btnlvl_b}, 0);
    wait_to(204);
    chk("lo_lvl", {31'd0, btnlvl_b}, 1);
    chk("lo_out_cyc", qat(q_out_b, 0), 204);
    wait_to(214);
    rst_b = 1'b0;
    btn_b = 1'b1;
    wait_to(215);
    chk("lo_rst_lvl", {31'd0, btnlvl_b}, 0);
    rst_b = 1'b1;
    wait_to(240);
    chk("lo_out_cnt", q_out_b.size(), 1);
    chk("lo_no_rel", q_rel_b.size(), 0);
    chk("lo_no_long", q_long_b.size(), 0);
    chk("lo_end_lvl", {31'd0, btnlvl_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
